lemon_ifu: RTL and testbench

Parametrised instruction-fetch unit for LemonPC, succeeding the combinational PC register and instruction read. Owns the fetch PC and issues sequential word requests over a valid/ready memory port, with multiple requests in flight. Buffers returned instructions in a DEPTH-entry FIFO with their PCs and presents them to decode over a valid/ready port. Supports redirect (branch/jump) with flush of both the buffer and in-flight responses.

---
 rtl/lemon_ifu_pkg.sv | 8 +
 rtl/ifu_fifo.sv | 58 +++++
 rtl/lemon_ifu.sv | 94 +++++++++
 tb/tb_lemon_ifu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lemon_ifu_pkg.sv
// Shared fetch constants for LemonPC: reset fetch address and instruction length.
// Imported by the fetch unit and reused by the core top.
package lemon_ifu_pkg;

    localparam logic [63:0] PC_INIT_DEFAULT = 64'h8000_0000;
    localparam int          INST_BYTES      = 4;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush and occupancy count; holds {pc, inst} for the fetch unit.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifu_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_push   = push && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; outputs are qualified by empty upstream.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Fetch credit accounting must never let a response land on a full buffer.
    assert property (@(posedge clk) disable iff (rst) !(do_push && full));

endmodule

// File: rtl/lemon_ifu.sv
// LemonPC instruction-fetch unit: issues sequential word fetches with several in flight,
// buffers responses with their PCs, and flushes/refetches on redirect.
module lemon_ifu
    import lemon_ifu_pkg::*;
#(
    parameter int              XLEN    = 64,
    parameter int              DEPTH   = 4,
    parameter logic [XLEN-1:0] PC_INIT = XLEN'(PC_INIT_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = XLEN + 32;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] redirect_base;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            empty;
    logic [FW-1:0]   head;

    assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};

    // Buffered plus outstanding never exceeds DEPTH, so every response has a slot.
    assign credit_used    = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push          = imem_resp_valid && !redirect_valid && (drop == '0);
    assign pop           = inst_valid && inst_ready && !redirect_valid;
    assign inflight_next = inflight + CW'(req_fire) - CW'(imem_resp_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= PC_INIT;
            resp_pc  <= PC_INIT;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect_valid) begin
                // Everything still outstanding belongs to the old stream.
                fetch_pc <= redirect_base;
                resp_pc  <= redirect_base;
                drop     <= inflight_next;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
                if (push)     resp_pc  <= resp_pc + XLEN'(INST_BYTES);
                if (imem_resp_valid && (drop != '0)) drop <= drop - CW'(1);
            end
        end
    end

    ifu_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({resp_pc, imem_resp_data}),
        .pop       (pop),
        .head_data (head),
        .count     (count),
        .empty     (empty)
    );

    assign inst_valid = !empty;
    assign inst       = inst_valid ? head[31:0] : '0;
    assign inst_pc    = inst_valid ? head[FW-1:32] : '0;

endmodule

// File: tb/tb_lemon_ifu.sv
// Scoreboard bench for lemon_ifu: a latency-programmable memory model answers requests,
// directed scenarios queue the expected PCs, and a monitor checks every consumed instruction.
module tb_lemon_ifu;

    localparam logic [63:0] PC_INIT = 64'h8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    lemon_ifu #(
        .XLEN    (64),
        .DEPTH   (4),
        .PC_INIT (PC_INIT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [63:0] exp_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int lat = 1;
    int req_issued = 0;
    int req_budget = 0;
    int n_deliv = 0;
    int first_deliv = 0;
    int last_deliv = 0;
    int c0 = 0;

    function automatic logic [31:0] mdata(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_1234 ^ {a[15:0], 16'h0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 64'(4 * i));
    endtask

    // Drive one cycle's inputs (just after negedge), then log any request that will fire.
    task automatic apply(input logic rdy, input logic redir, input logic [63:0] rpc);
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = (req_issued < req_budget);
        if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mdata(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #1;
        if (!rst && imem_req_valid && imem_req_ready) begin
            mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
            req_issued++;
        end
    endtask

    task automatic step(input logic rdy, input logic redir, input logic [63:0] rpc);
        @(negedge clk);
        cyc++;
        apply(rdy, redir, rpc);
    endtask

    task automatic do_reset(input int budget, input int latency, input logic rdy);
        rst = 1'b1;
        mem_q.delete();
        exp_q.delete();
        req_issued  = 0;
        req_budget  = budget;
        lat         = latency;
        n_deliv     = 0;
        first_deliv = 0;
        last_deliv  = 0;
        repeat (2) step(1'b0, 1'b0, 64'h0);
        chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
        chk("rst_inst_valid", 64'(inst_valid), 64'h0);
        chk("rst_inst", 64'(inst), 64'h0);
        chk("rst_inst_pc", inst_pc, 64'h0);
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        apply(rdy, 1'b0, 64'h0);
        chk("first_req_valid", 64'(imem_req_valid), 64'h1);
        chk("first_req_addr", imem_req_addr, PC_INIT);
        c0 = cyc;
    endtask

    // Monitor: every consumed instruction must match the head of the expected queue.
    always @(negedge clk) begin
        #2;
        if (!rst && inst_valid && inst_ready && !redirect_valid) begin
            n_deliv++;
            if (n_deliv == 1) first_deliv = cyc;
            last_deliv = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_inst: got pc %h with none expected", inst_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("inst_pc", inst_pc, e);
                chk("inst_data", 64'(inst), 64'(mdata(e)));
            end
        end
    end

    initial begin
        rst             = 1'b1;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'h0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;

        // Streaming: 1-cycle memory, decode always ready.
        do_reset(8, 1, 1'b1);
        push_exp(PC_INIT, 8);
        repeat (14) step(1'b1, 1'b0, 64'h0);
        chk("s1_count", 64'(n_deliv), 64'd8);
        chk("s1_first_cycle", 64'(first_deliv), 64'(c0 + 2));
        chk("s1_span", 64'(last_deliv - first_deliv), 64'd7);
        chk("s1_drain", 64'(exp_q.size()), 64'd0);

        // Decode stalled: credit caps requests at DEPTH.
        do_reset(6, 1, 1'b0);
        repeat (9) step(1'b0, 1'b0, 64'h0);
        chk("s2_reqs", 64'(req_issued), 64'd4);
        chk("s2_req_stall", 64'(imem_req_valid), 64'h0);
        push_exp(PC_INIT, 6);
        repeat (16) step(1'b1, 1'b0, 64'h0);
        chk("s2_count", 64'(n_deliv), 64'd6);
        chk("s2_drain", 64'(exp_q.size()), 64'd0);

        // Redirect with three requests in flight on a 5-cycle memory.
        do_reset(3, 5, 1'b1);
        repeat (2) step(1'b1, 1'b0, 64'h0);
        req_budget = 6;
        step(1'b1, 1'b1, 64'h8000_1002);
        step(1'b1, 1'b0, 64'h0);
        chk("s3_req_valid", 64'(imem_req_valid), 64'h1);
        chk("s3_req_addr", imem_req_addr, 64'h8000_1000);
        push_exp(64'h8000_1000, 3);
        repeat (20) step(1'b1, 1'b0, 64'h0);
        chk("s3_count", 64'(n_deliv), 64'd3);
        chk("s3_drain", 64'(exp_q.size()), 64'd0);

        // Response, request and pop together with two entries buffered.
        do_reset(10, 1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 64'h0);
        push_exp(PC_INIT, 10);
        step(1'b1, 1'b0, 64'h0);
        chk("s4_req_valid", 64'(imem_req_valid), 64'h1);
        repeat (20) step(1'b1, 1'b0, 64'h0);
        chk("s4_count", 64'(n_deliv), 64'd10);
        chk("s4_drain", 64'(exp_q.size()), 64'd0);

        // Back-to-back redirects with two requests in flight.
        do_reset(2, 4, 1'b1);
        step(1'b1, 1'b0, 64'h0);
        step(1'b1, 1'b1, 64'h100);
        req_budget = 5;
        step(1'b1, 1'b1, 64'h200);
        step(1'b1, 1'b0, 64'h0);
        chk("s5_req_valid", 64'(imem_req_valid), 64'h1);
        chk("s5_req_addr", imem_req_addr, 64'h200);
        push_exp(64'h200, 3);
        repeat (20) step(1'b1, 1'b0, 64'h0);
        chk("s5_count", 64'(n_deliv), 64'd3);
        chk("s5_drain", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset while an instruction is presented.
        do_reset(100, 1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 64'h0);
        chk("s6_pre_valid", 64'(inst_valid), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_async_inst_valid", 64'(inst_valid), 64'h0);
        chk("s6_async_req_valid", 64'(imem_req_valid), 64'h0);
        chk("s6_async_inst_pc", inst_pc, 64'h0);
        do_reset(2, 1, 1'b1);
        push_exp(PC_INIT, 2);
        repeat (8) step(1'b1, 1'b0, 64'h0);
        chk("s6_count", 64'(n_deliv), 64'd2);
        chk("s6_drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
